// File: rtl/uart_tx_engine.sv
// uart_tx_engine: 16550 transmit serializer.
// Pops bytes from the show-ahead TX FIFO and frames each one as a start bit,
// 5..8 data bits (LSB first), an optional parity bit and 1/1.5/2 stop bits.
// Every bit is timed from the 16x baud tick. tx_busy_o reports shifter
// activity so the register block can derive LSR.temt.
module uart_tx_engine #(
    // Baud ticks per bit. Must be even and >= 4 so that 1.5 stop bits is a
    // whole number of ticks.
    parameter int OVERSAMPLE = 16
) (
    input  logic       clk,
    input  logic       rst,
    input  logic       baud_tick_i,
    input  logic       tx_rst_i,
    input  logic [1:0] wls_i,
    input  logic       stb_i,
    input  logic       pen_i,
    input  logic       eps_i,
    input  logic       sticky_parity_i,
    input  logic       set_break_i,
    input  logic       tx_fifo_empty_i,
    input  logic [7:0] tx_fifo_data_i,
    output logic       tx_pop_o,
    output logic       tx_o,
    output logic       tx_busy_o
);

    // Tick counter must reach 2*OVERSAMPLE-1 for two stop bits.
    localparam int TW = $clog2(2 * OVERSAMPLE);

    localparam logic [TW-1:0] BIT_LAST    = TW'(OVERSAMPLE - 1);
    localparam logic [TW-1:0] STOP15_LAST = TW'((3 * OVERSAMPLE) / 2 - 1);
    localparam logic [TW-1:0] STOP2_LAST  = TW'(2 * OVERSAMPLE - 1);

    typedef enum logic [2:0] {
        IDLE,
        START,
        DATA,
        PARITY,
        STOP
    } state_t;

    state_t        state;
    logic [TW-1:0] tick_cnt;
    logic [2:0]    bit_cnt;
    logic [7:0]    shift_q;

    // Frame shadows: the LCR fields as they were when the byte was popped.
    // eps/sticky only matter through the parity bit, so the parity value
    // itself is what gets shadowed.
    logic [1:0]    wls_q;
    logic          stb_q;
    logic          pen_q;
    logic          par_q;

    logic [7:0]    word_mask;
    logic          par_new;
    logic [2:0]    last_bit;
    logic [TW-1:0] tick_last;
    logic          bit_end;
    logic          line_nxt;

    // Parity of the byte at the FIFO head under the live LCR; only sampled
    // on the pop cycle, bits above the word length are masked off.
    always_comb begin
        word_mask = 8'hFF;
        case (wls_i)
            2'b00:   word_mask = 8'h1F;
            2'b01:   word_mask = 8'h3F;
            2'b10:   word_mask = 8'h7F;
            default: word_mask = 8'hFF;
        endcase
        if (sticky_parity_i) begin
            par_new = ~eps_i;
        end else if (eps_i) begin
            par_new = ^(tx_fifo_data_i & word_mask);
        end else begin
            par_new = ~^(tx_fifo_data_i & word_mask);
        end
    end

    // Bit-end detection: each state lasts a fixed tick count from entry;
    // only STOP stretches to 1.5 or 2 bit times.
    always_comb begin
        last_bit  = 3'd4 + {1'b0, wls_q};
        tick_last = BIT_LAST;
        if (state == STOP && stb_q) begin
            tick_last = (wls_q == 2'b00) ? STOP15_LAST : STOP2_LAST;
        end
        bit_end = baud_tick_i && (state != IDLE) && (tick_cnt == tick_last);
    end

    // Undisturbed line level for the next cycle, i.e. the level belonging to
    // the state the FSM is about to be in. Break is applied on top of this.
    always_comb begin
        line_nxt = 1'b1;
        if (!tx_rst_i) begin
            case (state)
                IDLE:    line_nxt = tx_fifo_empty_i;
                START:   line_nxt = bit_end ? shift_q[0] : 1'b0;
                DATA: begin
                    if (bit_end && bit_cnt == last_bit) begin
                        line_nxt = pen_q ? par_q : 1'b1;
                    end else if (bit_end) begin
                        line_nxt = shift_q[1];
                    end else begin
                        line_nxt = shift_q[0];
                    end
                end
                PARITY:  line_nxt = bit_end ? 1'b1 : par_q;
                STOP:    line_nxt = 1'b1;
                default: line_nxt = 1'b1;
            endcase
        end
    end

    // Frame FSM with registered pop, line and busy outputs.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state     <= IDLE;
            tick_cnt  <= '0;
            bit_cnt   <= '0;
            shift_q   <= '0;
            wls_q     <= '0;
            stb_q     <= 1'b0;
            pen_q     <= 1'b0;
            par_q     <= 1'b0;
            tx_pop_o  <= 1'b0;
            tx_o      <= 1'b1;
            tx_busy_o <= 1'b0;
        end else begin
            tx_pop_o <= 1'b0;
            // Break is not shadowed: it forces the line low in any state
            // while the FSM keeps running underneath.
            tx_o     <= line_nxt & ~set_break_i;

            if (tx_rst_i) begin
                // Abort wins over everything, including a bit end this cycle;
                // the in-flight byte is simply dropped.
                state     <= IDLE;
                tick_cnt  <= '0;
                bit_cnt   <= '0;
                tx_busy_o <= 1'b0;
            end else begin
                if (state != IDLE && baud_tick_i) begin
                    tick_cnt <= bit_end ? '0 : tick_cnt + 1'b1;
                end

                case (state)
                    IDLE: begin
                        if (!tx_fifo_empty_i) begin
                            tx_pop_o  <= 1'b1;
                            shift_q   <= tx_fifo_data_i;
                            wls_q     <= wls_i;
                            stb_q     <= stb_i;
                            pen_q     <= pen_i;
                            par_q     <= par_new;
                            tick_cnt  <= '0;
                            bit_cnt   <= '0;
                            state     <= START;
                            tx_busy_o <= 1'b1;
                        end
                    end
                    START: begin
                        if (bit_end) begin
                            state <= DATA;
                        end
                    end
                    DATA: begin
                        if (bit_end) begin
                            if (bit_cnt == last_bit) begin
                                bit_cnt <= '0;
                                state   <= pen_q ? PARITY : STOP;
                            end else begin
                                bit_cnt <= bit_cnt + 3'd1;
                                shift_q <= {1'b0, shift_q[7:1]};
                            end
                        end
                    end
                    PARITY: begin
                        if (bit_end) begin
                            state <= STOP;
                        end
                    end
                    STOP: begin
                        // Always pass through IDLE for at least one clk so the
                        // pop decision is made from a clean state.
                        if (bit_end) begin
                            state     <= IDLE;
                            tx_busy_o <= 1'b0;
                        end
                    end
                    default: begin
                        state     <= IDLE;
                        tx_busy_o <= 1'b0;
                    end
                endcase
            end
        end
    end

endmodule

// File: doc/uart_tx_engine.md
Name: uart_tx_engine

Overview:
- Transmit serializer for the 16550 controller. It pops bytes from the TX FIFO, frames them per LCR (start, 5–8 data bits LSB-first, optional parity, 1/1.5/2 stop bits) and drives the serial line.
- Bit timing comes from the 16x baud tick generated by the register block.
- Also reports shifter activity so the register block can derive LSR.temt.

Parameters:
- OVERSAMPLE, 16: baud ticks per bit. Must be even, >=4.

Ports:
- clk  input  1  clock
- rst  input  1  reset, asynchronous, active-high
- baud_tick_i  input  1  one-clk pulse per oversample tick (16x baud)
- tx_rst_i  input  1  synchronous abort (FCR tx_rst pulse)
- wls_i  input  2  word length select: 00=5, 01=6, 10=7, 11=8 bits
- stb_i  input  1  stop bits: 0=1 bit, 1=2 bits (1.5 when wls_i=00)
- pen_i  input  1  parity enable
- eps_i  input  1  even parity select
- sticky_parity_i  input  1  stick parity
- set_break_i  input  1  force line low
- tx_fifo_empty_i  input  1  TX FIFO empty
- tx_fifo_data_i  input  8  FIFO head data (show-ahead, valid when not empty)
- tx_pop_o  output  1  one-clk pop strobe
- tx_o  output  1  serial line, idle high
- tx_busy_o  output  1  high whenever state != IDLE

Behaviour:
- Reset values: tx_o=1, tx_pop_o=0, tx_busy_o=0, state=IDLE, tick counter=0, bit counter=0.
- All outputs are registered.
- States: IDLE, START, DATA, PARITY, STOP.
- IDLE:
  - When tx_fifo_empty_i=0: tx_pop_o=1 for exactly one clk.
  - In that same clk: capture tx_fifo_data_i into the shift register, and latch wls/stb/pen/eps/sticky_parity into frame shadows.
  - Next state START. tx_o goes 0 on the following edge.
  - No pop is issued in any other state.
- Frame shadows are held for the whole frame. LCR changes mid-frame affect only the next frame. set_break_i is NOT shadowed.
- Tick counter:
  - Cleared on each state entry. Increments on baud_tick_i.
  - A bit ends on the clk where baud_tick_i=1 and the counter equals OVERSAMPLE-1.
  - Each bit therefore lasts exactly OVERSAMPLE ticks from state entry; ticks arriving before entry are not counted.
- START: tx_o=0 for one bit, then DATA.
- DATA:
  - tx_o = shift[0]. Shift right at each bit end.
  - Bit counter runs 0..N-1, with N = 5 + wls shadow.
  - After bit N-1: go to PARITY if pen, else STOP.
- PARITY bit value:
  - sticky=1: bit = ~eps.
  - else eps=1 (even): bit = XOR of the N data bits.
  - else (odd): bit = ~XOR.
  - Bits above N-1 of the captured byte are ignored.
- STOP:
  - tx_o=1.
  - Duration: OVERSAMPLE ticks if stb=0; 2*OVERSAMPLE if stb=1 and N>5; 3*OVERSAMPLE/2 if stb=1 and N=5. Tick counter is wide enough for 2*OVERSAMPLE.
  - At end, go to IDLE. Minimum one clk in IDLE between frames, so back-to-back frames have a 1-clk gap plus tick alignment.
- Break: while set_break_i=1, tx_o=0 regardless of state. The FSM, counters and pops continue normally. On release, tx_o returns to the state's value on the next edge.
- tx_rst_i=1 in any state:
  - Next edge: state=IDLE, tx_o=1, tx_pop_o=0, counters cleared.
  - The in-flight byte is discarded.
  - No pop occurs in the tx_rst_i cycle, even if the FIFO is non-empty.
  - Takes priority over a simultaneous bit end.
- Async rst mid-frame: outputs go immediately to their reset values.
- baud_tick_i held constantly high is legal: one tick per clk.

Test Plan:
- 8N1, data 0x55, baud_tick_i=1 every clk, FIFO holds one byte -> one tx_pop_o pulse; tx_o = 0, then 1,0,1,0,1,0,1,0, then 1, each level 16 clks; tx_busy_o high for 160 clks, then 0.
- 8-bit, pen=1, data 0x07 -> parity bit 1 with eps=1, 0 with eps=0; with sticky=1, eps=1 -> parity bit 0, and eps=0 -> parity bit 1.
- wls=00, stb=1, no parity, data 0xFF -> 5 data bits all 1 (bits 7:5 ignored); stop lasts 24 ticks; frame is 16+80+24=120 ticks. wls=11, stb=1 -> stop lasts 32 ticks.
- set_break_i asserted during DATA for 40 clks -> tx_o=0 for those 40 clks; frame completes on schedule; tx_o=1 after STOP.
- tx_rst_i pulsed at data bit 3 with FIFO non-empty -> next edge tx_o=1, tx_busy_o=0; no pop in that cycle; a new frame starts with a pop on the following clk.
- Two bytes queued, wls changed from 11 to 10 during frame 1 -> frame 1 sends 8 bits and frame 2 sends 7; exactly one IDLE clk between STOP end and the second pop; exactly two pops total.
